alu_uart_sequencer: RTL and testbench

Sequencer that sits directly upstream and downstream of the 8-bit ALU. It collects three bytes (A, B, opcode) from the UART receiver and pulses the ALU load enables `e1`/`e2`/`e3` with the byte on the ALU `data` bus. It then captures the ALU result and flags and returns two bytes (result, flags) through the UART transmitter handshake. This replaces switch/button operand entry on the board.

---
 rtl/alu_uart_sequencer_pkg.sv | 32 +++
 rtl/alu_uart_sequencer_interbyte_timer.sv | 37 +++
 rtl/alu_uart_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_uart_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_uart_sequencer_pkg.sv
// Shared constants for the ALU/UART sequencer: state encoding, flag bit positions,
// ALU opcodes and the inter-byte counter width helper.
package alu_uart_sequencer_pkg;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [STATE_W-1:0] S_A      = 3'd0;
    localparam logic [STATE_W-1:0] S_B      = 3'd1;
    localparam logic [STATE_W-1:0] S_OP     = 3'd2;
    localparam logic [STATE_W-1:0] S_EXEC   = 3'd3;
    localparam logic [STATE_W-1:0] S_CAPT   = 3'd4;
    localparam logic [STATE_W-1:0] S_TX_RES = 3'd5;
    localparam logic [STATE_W-1:0] S_TX_FLG = 3'd6;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_NEG   = 3;

    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;

    // A zero timeout still needs a 1-bit counter to keep the port widths legal.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/alu_uart_sequencer_interbyte_timer.sv
// Inter-byte idle counter; expiry is a combinational pulse when the count hits the limit.
// Latency: expiry asserts TIMEOUT_CYCLES enabled cycles after the last clear; no backpressure.
module interbyte_timer #(
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int CNT_W          = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    always_comb begin
        hit = (TIMEOUT_CYCLES != 0) && en && !clr && (cnt_q == LAST);
        cnt_d = cnt_q + 1'b1;
        if (TIMEOUT_CYCLES == 0 || clr || !en || hit) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = hit;

endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects A, B, opcode bytes from the UART into the ALU, then returns result and flags.
// Latency: opcode byte to tx_start is 3 cycles; tx_done paces the two return bytes.
module alu_uart_sequencer
    import alu_uart_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int OPCODE_WIDTH   = 6,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_done,
    input  logic                  tx_done,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_carry,
    input  logic                  alu_overflow,
    input  logic                  alu_neg,
    output logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_e1,
    output logic                  alu_e2,
    output logic                  alu_e3,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_start,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] alu_data_q, alu_data_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [DATA_WIDTH-1:0] flags_q, flags_d;
    logic                  e1_q, e1_d, e2_q, e2_d, e3_q, e3_d;
    logic                  tx_start_q, tx_start_d;
    logic                  busy_q, busy_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  timer_en, timer_expired;
    logic [DATA_WIDTH-1:0] op_byte, capt_flags;

    // The whole byte goes to the ALU; it decodes only the low OPCODE_WIDTH bits itself.
    assign op_byte = {rx_data[DATA_WIDTH-1:OPCODE_WIDTH], rx_data[OPCODE_WIDTH-1:0]};

    assign timer_en = (state_q == S_B) || (state_q == S_OP);

    interbyte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (rx_done),
        .en     (timer_en),
        .expired(timer_expired)
    );

    always_comb begin
        capt_flags            = '0;
        capt_flags[FLG_ZERO]  = alu_zero;
        capt_flags[FLG_CARRY] = alu_carry;
        capt_flags[FLG_OVF]   = alu_overflow;
        capt_flags[FLG_NEG]   = alu_neg;
    end

    always_comb begin
        state_d       = state_q;
        alu_data_d    = alu_data_q;
        tx_data_d     = tx_data_q;
        flags_d       = flags_q;
        e1_d          = 1'b0;
        e2_d          = 1'b0;
        e3_d          = 1'b0;
        tx_start_d    = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            S_A: begin
                if (rx_done) begin
                    alu_data_d = rx_data;
                    e1_d       = 1'b1;
                    state_d    = S_B;
                end
            end
            // A byte arriving on the expiry cycle still counts; rx_done is checked first.
            S_B: begin
                if (rx_done) begin
                    alu_data_d = rx_data;
                    e2_d       = 1'b1;
                    state_d    = S_OP;
                end else if (timer_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_A;
                end
            end
            S_OP: begin
                if (rx_done) begin
                    alu_data_d = op_byte;
                    e3_d       = 1'b1;
                    state_d    = S_EXEC;
                end else if (timer_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_A;
                end
            end
            S_EXEC: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                tx_data_d  = alu_result;
                flags_d    = capt_flags;
                tx_start_d = 1'b1;
                state_d    = S_TX_RES;
            end
            S_TX_RES: begin
                if (tx_done) begin
                    tx_data_d  = flags_q;
                    tx_start_d = 1'b1;
                    state_d    = S_TX_FLG;
                end
            end
            S_TX_FLG: begin
                if (tx_done) begin
                    state_d = S_A;
                end
            end
            default: begin
                state_d = S_A;
            end
        endcase
        busy_d = (state_d != S_A);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_A;
            alu_data_q    <= '0;
            tx_data_q     <= '0;
            flags_q       <= '0;
            e1_q          <= 1'b0;
            e2_q          <= 1'b0;
            e3_q          <= 1'b0;
            tx_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_data_q    <= alu_data_d;
            tx_data_q     <= tx_data_d;
            flags_q       <= flags_d;
            e1_q          <= e1_d;
            e2_q          <= e2_d;
            e3_q          <= e3_d;
            tx_start_q    <= tx_start_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign alu_data    = alu_data_q;
    assign alu_e1      = e1_q;
    assign alu_e2      = e2_q;
    assign alu_e3      = e3_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench: a small ALU register model closes the loop; expected tx bytes are hand-computed.
module tb_alu_uart_sequencer;
    import alu_uart_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] alu_result;
    logic       alu_zero, alu_carry, alu_overflow, alu_neg;
    logic [7:0] alu_data;
    logic       alu_e1, alu_e2, alu_e3;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_uart_sequencer #(
        .DATA_WIDTH    (8),
        .OPCODE_WIDTH  (6),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .tx_done     (tx_done),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_carry   (alu_carry),
        .alu_overflow(alu_overflow),
        .alu_neg     (alu_neg),
        .alu_data    (alu_data),
        .alu_e1      (alu_e1),
        .alu_e2      (alu_e2),
        .alu_e3      (alu_e3),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // ALU stand-in: operand/opcode registers loaded by the enables, combinational result.
    logic [7:0] a_r = 8'h00, b_r = 8'h00, op_r = 8'h00;
    always @(posedge clk) begin
        if (alu_e1) a_r <= alu_data;
        if (alu_e2) b_r <= alu_data;
        if (alu_e3) op_r <= alu_data;
    end

    always_comb begin
        logic [8:0] wide;
        wide         = 9'h000;
        alu_result   = 8'h00;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (op_r)
            OP_ADD: begin
                wide         = {1'b0, a_r} + {1'b0, b_r};
                alu_result   = wide[7:0];
                alu_carry    = wide[8];
                alu_overflow = (a_r[7] == b_r[7]) && (alu_result[7] != a_r[7]);
            end
            OP_SUB: begin
                alu_result   = a_r - b_r;
                alu_carry    = (a_r >= b_r);
                alu_overflow = (a_r[7] != b_r[7]) && (alu_result[7] != a_r[7]);
            end
            OP_SRA: alu_result = 8'($signed(a_r) >>> b_r[2:0]);
            default: alu_result = 8'h00;
        endcase
        alu_zero = (alu_result == 8'h00);
        alu_neg  = alu_result[7];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [2:0] en_exp, input string nm);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        check({nm, "_en"}, {alu_e3, alu_e2, alu_e1}, en_exp);
        check({nm, "_data"}, alu_data, b);
    endtask

    // mode 0: normal, 1: stray rx byte during result transmit, 2: reset between the tx_done pulses
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input logic [7:0] exp_res, input logic [7:0] exp_flg, input int mode);
        int cyc;
        send_byte(a, 3'b001, "byte_a");
        check("busy_after_a", busy, 1);
        send_byte(b, 3'b010, "byte_b");
        send_byte(op, 3'b100, "byte_op");
        cyc = 0;
        while (!tx_start && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("tx_res_latency", cyc, 2);
        check("tx_res_data", tx_data, exp_res);
        if (mode == 1) begin
            rx_data = 8'h55;
            rx_done = 1'b1;
            @(negedge clk);
            rx_done = 1'b0;
            check("drop_no_enable", {alu_e3, alu_e2, alu_e1}, 3'b000);
            check("drop_data_held", alu_data, op);
        end else begin
            @(negedge clk);
        end
        check("tx_start_one_cycle", tx_start, 0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("tx_flg_start", tx_start, 1);
        check("tx_flg_data", tx_data, exp_flg);
        if (mode == 2) begin
            #2 reset = 1'b1;
            #1;
            check("reset_outputs", {alu_data, tx_data, tx_start, alu_e1, alu_e2, alu_e3,
                                    busy, timeout_err}, 0);
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        @(negedge clk);
        check("busy_in_tx_flg", busy, 1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("busy_end", busy, 0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] res;
        logic [7:0] flg;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        int   cyc;
        logic saw_e3;

        vecs[0] = '{8'h7F, 8'h01, OP_ADD, 8'h80, 8'h0C};
        vecs[1] = '{8'h05, 8'h05, OP_SUB, 8'h00, 8'h03};
        vecs[2] = '{8'h80, 8'h03, OP_SRA, 8'hF0, 8'h08};
        vecs[3] = '{8'h80, 8'h01, OP_SUB, 8'h7F, 8'h06};

        reset   = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {alu_data, tx_data, tx_start, alu_e1, alu_e2, alu_e3,
                              busy, timeout_err}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg, 0);
        end

        // Timeout after B: 50 idle cycles in S_OP abort the frame.
        send_byte(8'h11, 3'b001, "to_a");
        send_byte(8'h22, 3'b010, "to_b");
        cyc    = 0;
        saw_e3 = 1'b0;
        while (!timeout_err && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (alu_e3) saw_e3 = 1'b1;
        end
        check("timeout_latency", cyc, 50);
        check("timeout_no_e3", saw_e3, 0);
        check("timeout_busy", busy, 0);
        @(negedge clk);
        check("timeout_pulse_width", timeout_err, 0);
        run_frame(8'h01, 8'h02, OP_ADD, 8'h03, 8'h00, 0);

        run_frame(8'h05, 8'h05, OP_SUB, 8'h00, 8'h03, 1);
        run_frame(8'h7F, 8'h01, OP_ADD, 8'h80, 8'h0C, 0);

        run_frame(8'h7F, 8'h01, OP_ADD, 8'h80, 8'h0C, 2);
        check("post_reset_busy", busy, 0);
        run_frame(8'h03, 8'h04, OP_ADD, 8'h07, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
